clock_gate_ctrl: RTL and testbench

Idle-detect controller that drives the enable input of the latch-based clock-gating cell. It runs on the free-running clock. It gates the downstream clock after a programmable number of consecutive idle cycles and re-enables it on activity or on an explicit wake request. Wake requests are acknowledged only after a settle period, so requesters never see a half-started clock domain. It sits beside each gated region, between activity/wake sources and the gating cell's `en_i`.

---
 rtl/clock_gate_pkg.sv | 16 +
 rtl/clock_gate_ctrl_if.sv | 22 ++
 rtl/clock_gate_ctrl.sv | 125 ++++++++++++
 tb/tb_clock_gate_ctrl.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/clock_gate_pkg.sv
// Shared types and constants for the idle-detect clock-gate controller.
package clock_gate_pkg;

  typedef enum logic [1:0] {
    CG_RUN   = 2'd0,
    CG_GATED = 2'd1,
    CG_WAKE  = 2'd2
  } cg_state_e;

  localparam int unsigned CgEventW = 16;

  function automatic int unsigned cg_max(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/clock_gate_ctrl_if.sv
// Activity/wake sources on one side, gating-cell enable and status on the other.
interface clock_gate_ctrl_if;
  import clock_gate_pkg::*;

  logic                busy_i;
  logic                wake_req_i;
  logic                cg_disable_i;
  logic                clk_en_o;
  logic                wake_ack_o;
  logic                gated_o;
  logic [CgEventW-1:0] gate_events_o;

  modport master (
    output busy_i, wake_req_i, cg_disable_i,
    input  clk_en_o, wake_ack_o, gated_o, gate_events_o
  );

  modport slave (
    input  busy_i, wake_req_i, cg_disable_i,
    output clk_en_o, wake_ack_o, gated_o, gate_events_o
  );
endinterface

// File: rtl/clock_gate_ctrl.sv
// Gates the downstream clock after IdleCycles idle samples and re-enables it on
// activity, wake request or disable; wake requests are acked after a settle period.
module clock_gate_ctrl
  import clock_gate_pkg::*;
#(
  parameter int IdleCycles = 16,
  parameter int WakeCycles = 2
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  clock_gate_ctrl_if.slave   cg_if
);

  if (IdleCycles < 1) begin : g_bad_idle
    $error("clock_gate_ctrl: IdleCycles must be >= 1");
  end
  if (WakeCycles < 1) begin : g_bad_wake
    $error("clock_gate_ctrl: WakeCycles must be >= 1");
  end

  localparam int unsigned MaxCycles = cg_max(int'(IdleCycles), int'(WakeCycles));
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);
  localparam logic [CntW-1:0] IdleLast = CntW'(IdleCycles - 1);
  localparam logic [CntW-1:0] WakeLast = CntW'(WakeCycles - 1);

  cg_state_e           state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                clk_en_q, clk_en_d;
  logic                wake_ack_q, wake_ack_d;
  logic                gated_q, gated_d;
  logic [CgEventW-1:0] gate_events_q, gate_events_d;

  logic idle;
  logic wake_cond;

  assign idle      = !cg_if.busy_i && !cg_if.wake_req_i && !cg_if.cg_disable_i;
  assign wake_cond = cg_if.busy_i || cg_if.wake_req_i || cg_if.cg_disable_i;

  // Next-state and registered-output computation.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    clk_en_d      = clk_en_q;
    wake_ack_d    = 1'b0;
    gated_d       = gated_q;
    gate_events_d = gate_events_q;

    unique case (state_q)
      CG_RUN: begin
        clk_en_d   = 1'b1;
        gated_d    = 1'b0;
        wake_ack_d = cg_if.wake_req_i && !wake_ack_q;
        if (idle) begin
          if (cnt_q == IdleLast) begin
            state_d       = CG_GATED;
            cnt_d         = '0;
            clk_en_d      = 1'b0;
            gated_d       = 1'b1;
            gate_events_d = gate_events_q + CgEventW'(1);
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end else begin
          cnt_d = '0;
        end
      end

      CG_GATED: begin
        clk_en_d = 1'b0;
        gated_d  = 1'b1;
        if (wake_cond) begin
          state_d  = CG_WAKE;
          cnt_d    = '0;
          clk_en_d = 1'b1;
          gated_d  = 1'b0;
        end
      end

      CG_WAKE: begin
        // Settle window: inputs are ignored until the clock domain is running.
        clk_en_d = 1'b1;
        gated_d  = 1'b0;
        if (cnt_q == WakeLast) begin
          state_d    = CG_RUN;
          cnt_d      = '0;
          wake_ack_d = cg_if.wake_req_i;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      default: begin
        state_d  = CG_RUN;
        cnt_d    = '0;
        clk_en_d = 1'b1;
        gated_d  = 1'b0;
      end
    endcase
  end

  // State and output registers, synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q       <= CG_RUN;
      cnt_q         <= '0;
      clk_en_q      <= 1'b1;
      wake_ack_q    <= 1'b0;
      gated_q       <= 1'b0;
      gate_events_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      clk_en_q      <= clk_en_d;
      wake_ack_q    <= wake_ack_d;
      gated_q       <= gated_d;
      gate_events_q <= gate_events_d;
    end
  end

  assign cg_if.clk_en_o      = clk_en_q;
  assign cg_if.wake_ack_o    = wake_ack_q;
  assign cg_if.gated_o       = gated_q;
  assign cg_if.gate_events_o = gate_events_q;

endmodule

// File: tb/tb_clock_gate_ctrl.sv
// Directed bench for clock_gate_ctrl with IdleCycles=4, WakeCycles=2.
module tb_clock_gate_ctrl;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  clock_gate_ctrl_if cg_if ();

  clock_gate_ctrl #(.IdleCycles(4), .WakeCycles(2)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .cg_if  (cg_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic busy, input logic wake, input logic dis);
    cg_if.busy_i       = busy;
    cg_if.wake_req_i   = wake;
    cg_if.cg_disable_i = dis;
  endtask

  task automatic wake_by_busy();
    set_in(1'b1, 1'b0, 1'b0);
    step(1);
    checks++; if (cg_if.clk_en_o !== 1'b1) begin errors++; $display("FAIL busy_wake_en: got %b expected 1", cg_if.clk_en_o); end
    step(2);
    checks++; if (cg_if.wake_ack_o !== 1'b0) begin errors++; $display("FAIL busy_wake_noack: got %b expected 0", cg_if.wake_ack_o); end
  endtask

  task automatic go_gated();
    set_in(1'b0, 1'b0, 1'b0);
    step(4);
    checks++; if (cg_if.gated_o !== 1'b1) begin errors++; $display("FAIL go_gated: got %b expected 1", cg_if.gated_o); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      set_in(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      step(1);
    end
    checks++; if (cg_if.clk_en_o !== 1'b1) begin errors++; $display("FAIL reset_clk_en: got %b expected 1", cg_if.clk_en_o); end
    checks++; if (cg_if.gated_o !== 1'b0) begin errors++; $display("FAIL reset_gated: got %b expected 0", cg_if.gated_o); end
    checks++; if (cg_if.wake_ack_o !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b expected 0", cg_if.wake_ack_o); end
    checks++; if (cg_if.gate_events_o !== 16'h0000) begin errors++; $display("FAIL reset_events: got %h expected 0000", cg_if.gate_events_o); end
    set_in(1'b1, 1'b0, 1'b0);
    rst_n = 1'b1;
    step(1);
    checks++; if (cg_if.clk_en_o !== 1'b1) begin errors++; $display("FAIL post_reset_en: got %b expected 1", cg_if.clk_en_o); end
  endtask

  task automatic test_gate();
    set_in(1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      step(1);
      checks++; if (cg_if.clk_en_o !== (k < 4)) begin errors++; $display("FAIL gate_latency edge %0d: got %b expected %b", k, cg_if.clk_en_o, (k < 4)); end
    end
    checks++; if (cg_if.gated_o !== 1'b1) begin errors++; $display("FAIL gate_status: got %b expected 1", cg_if.gated_o); end
    checks++; if (cg_if.gate_events_o !== 16'd1) begin errors++; $display("FAIL gate_events1: got %h expected 0001", cg_if.gate_events_o); end
    wake_by_busy();
  endtask

  task automatic test_idle_abort();
    set_in(1'b0, 1'b0, 1'b0);
    step(3);
    set_in(1'b1, 1'b0, 1'b0);
    step(1);
    checks++; if (cg_if.clk_en_o !== 1'b1) begin errors++; $display("FAIL abort_threshold: got %b expected 1", cg_if.clk_en_o); end
    set_in(1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      step(1);
      checks++; if (cg_if.clk_en_o !== (k < 4)) begin errors++; $display("FAIL abort_restart edge %0d: got %b expected %b", k, cg_if.clk_en_o, (k < 4)); end
    end
    checks++; if (cg_if.gate_events_o !== 16'd2) begin errors++; $display("FAIL abort_events: got %h expected 0002", cg_if.gate_events_o); end
  endtask

  task automatic test_wake_req();
    set_in(1'b0, 1'b1, 1'b0);
    step(1);
    checks++; if (cg_if.clk_en_o !== 1'b1) begin errors++; $display("FAIL wake_en: got %b expected 1", cg_if.clk_en_o); end
    checks++; if (cg_if.gated_o !== 1'b0) begin errors++; $display("FAIL wake_gated: got %b expected 0", cg_if.gated_o); end
    checks++; if (cg_if.wake_ack_o !== 1'b0) begin errors++; $display("FAIL wake_early_ack1: got %b expected 0", cg_if.wake_ack_o); end
    step(1);
    checks++; if (cg_if.wake_ack_o !== 1'b0) begin errors++; $display("FAIL wake_early_ack2: got %b expected 0", cg_if.wake_ack_o); end
    step(1);
    checks++; if (cg_if.wake_ack_o !== 1'b1) begin errors++; $display("FAIL wake_ack: got %b expected 1", cg_if.wake_ack_o); end
    set_in(1'b1, 1'b0, 1'b0);
    step(1);
    checks++; if (cg_if.wake_ack_o !== 1'b0) begin errors++; $display("FAIL wake_ack_pulse: got %b expected 0", cg_if.wake_ack_o); end
    checks++; if (cg_if.clk_en_o !== 1'b1) begin errors++; $display("FAIL wake_run_en: got %b expected 1", cg_if.clk_en_o); end
  endtask

  task automatic test_back_to_back_ack();
    logic exp_ack [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    set_in(1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step(1);
      checks++; if (cg_if.wake_ack_o !== exp_ack[k]) begin errors++; $display("FAIL reack cycle %0d: got %b expected %b", k, cg_if.wake_ack_o, exp_ack[k]); end
    end
    set_in(1'b1, 1'b0, 1'b0);
    step(1);
    checks++; if (cg_if.wake_ack_o !== exp_ack[3]) begin errors++; $display("FAIL reack_drop: got %b expected %b", cg_if.wake_ack_o, exp_ack[3]); end
  endtask

  task automatic test_cg_disable();
    int bad;
    go_gated();
    set_in(1'b0, 1'b0, 1'b1);
    step(1);
    checks++; if (cg_if.clk_en_o !== 1'b1) begin errors++; $display("FAIL disable_wake: got %b expected 1", cg_if.clk_en_o); end
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      step(1);
      checks++; if (cg_if.clk_en_o !== 1'b1 || cg_if.gated_o !== 1'b0) begin errors++; bad++; $display("FAIL disable_hold cycle %0d: got en=%b gated=%b expected en=1 gated=0", k, cg_if.clk_en_o, cg_if.gated_o); end
    end
    set_in(1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      step(1);
      checks++; if (cg_if.clk_en_o !== (k < 4)) begin errors++; $display("FAIL disable_release edge %0d: got %b expected %b", k, cg_if.clk_en_o, (k < 4)); end
    end
    checks++; if (cg_if.gate_events_o !== 16'd4) begin errors++; $display("FAIL disable_events: got %h expected 0004 (hold faults %0d)", cg_if.gate_events_o, bad); end
  endtask

  task automatic test_reset_mid();
    wake_by_busy();
    go_gated();
    checks++; if (cg_if.gate_events_o !== 16'h0005) begin errors++; $display("FAIL mid_pre_events: got %h expected 0005", cg_if.gate_events_o); end
    rst_n = 1'b0;
    step(1);
    checks++; if (cg_if.clk_en_o !== 1'b1) begin errors++; $display("FAIL mid_reset_en: got %b expected 1", cg_if.clk_en_o); end
    checks++; if (cg_if.gated_o !== 1'b0) begin errors++; $display("FAIL mid_reset_gated: got %b expected 0", cg_if.gated_o); end
    checks++; if (cg_if.gate_events_o !== 16'h0000) begin errors++; $display("FAIL mid_reset_events: got %h expected 0000", cg_if.gate_events_o); end
    set_in(1'b1, 1'b0, 1'b0);
    rst_n = 1'b1;
    step(1);
  endtask

  task automatic test_wrap();
    go_gated();
    force dut.gate_events_q = 16'hFFFF;
    step(1);
    release dut.gate_events_q;
    step(1);
    checks++; if (cg_if.gate_events_o !== 16'hFFFF) begin errors++; $display("FAIL wrap_preload: got %h expected ffff", cg_if.gate_events_o); end
    wake_by_busy();
    go_gated();
    checks++; if (cg_if.gate_events_o !== 16'h0000) begin errors++; $display("FAIL wrap_events: got %h expected 0000", cg_if.gate_events_o); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    set_in(1'b1, 1'b0, 1'b0);
    test_reset();
    test_gate();
    test_idle_abort();
    test_wake_req();
    test_back_to_back_ack();
    test_cg_disable();
    test_reset_mid();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
